led_pattern_scheduler: RTL and testbench

Controller that sequences the 8-bit LED bank through selectable animation patterns (KIT bounce scanner, chase, blink, binary count). It owns the step-rate prescaler, accepts mode/rate commands over a valid/ready handshake, and supports pause. On every mode change it inserts a blanking interval. Sits between the board-level control logic (buttons/UART) and the LED pins.

---
 rtl/led_pattern_scheduler.sv | 134 +++++++++++++
 tb/tb_led_pattern_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_scheduler.sv
// LED bank animation sequencer: prescaled step ticks drive a per-mode index,
// with a blanking interval after every mode change and a level-sensitive pause.
module led_pattern_scheduler #(
  parameter int unsigned          DIV_WIDTH   = 24,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 24'd999_999,
  parameter int unsigned          BLANK_STEPS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [2:0]           i_cmd_mode,
  input  logic [DIV_WIDTH-1:0] i_cmd_div,
  output logic                 o_cmd_ready,
  input  logic                 i_pause,
  output logic [7:0]           o_led,
  output logic                 o_step,
  output logic [2:0]           o_mode
);
  localparam int BW = (BLANK_STEPS < 1) ? 1 : $clog2(BLANK_STEPS + 1);

  localparam logic [2:0] M_OFF = 3'd0, M_KIT = 3'd1, M_CHASE = 3'd2,
                         M_BLINK = 3'd3, M_COUNT = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_RUN, S_PAUSE} state_t;

  typedef struct packed {
    logic [2:0]           mode;
    logic [DIV_WIDTH-1:0] div;
  } cmd_t;

  state_t               state, state_n;
  cmd_t                 cur, cur_n;
  logic [DIV_WIDTH-1:0] presc, presc_n;
  logic [7:0]           idx, idx_n;
  logic [BW-1:0]        blank, blank_n;
  logic [7:0]           led_n;
  logic                 step_n;
  logic                 accept, tick;
  logic [2:0]           req_mode;

  function automatic logic [7:0] decode(input logic [2:0] m, input logic [7:0] i);
    logic [3:0] r;
    r = 4'd14 - i[3:0];
    case (m)
      M_KIT:   decode = (i < 8'd8) ? (8'd1 << i[2:0]) : (8'd1 << r[2:0]);
      M_CHASE: decode = 8'd1 << i[2:0];
      M_BLINK: decode = i[0] ? 8'hFF : 8'h00;
      M_COUNT: decode = i;
      default: decode = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] advance(input logic [2:0] m, input logic [7:0] i);
    case (m)
      M_KIT:   advance = (i >= 8'd13) ? 8'd0 : i + 8'd1;
      M_CHASE: advance = {5'd0, i[2:0] + 3'd1};
      M_BLINK: advance = {7'd0, ~i[0]};
      default: advance = i + 8'd1;
    endcase
  endfunction

  assign o_cmd_ready = (state != S_BLANK);
  assign accept      = i_cmd_valid & o_cmd_ready;
  assign tick        = ((state == S_BLANK) || (state == S_RUN)) && (presc == cur.div);
  assign req_mode    = (i_cmd_mode > M_COUNT) ? M_OFF : i_cmd_mode;
  assign o_mode      = cur.mode;

  always_comb begin
    state_n = state;
    cur_n   = cur;
    presc_n = presc;
    idx_n   = idx;
    blank_n = blank;
    led_n   = o_led;
    step_n  = 1'b0;
    // A command pre-empts everything, including a coincident tick.
    if (accept) begin
      cur_n   = '{mode: req_mode, div: i_cmd_div};
      presc_n = '0;
      idx_n   = '0;
      led_n   = 8'h00;
      blank_n = BW'(BLANK_STEPS);
      if (req_mode == M_OFF)     state_n = S_IDLE;
      else if (BLANK_STEPS == 0) state_n = S_RUN;
      else                       state_n = S_BLANK;
    end else begin
      case (state)
        S_IDLE: led_n = 8'h00;
        S_BLANK: begin
          led_n   = 8'h00;
          presc_n = tick ? '0 : presc + DIV_WIDTH'(1);
          if (tick) begin
            blank_n = blank - BW'(1);
            if (blank == BW'(1)) begin
              state_n = S_RUN;
              idx_n   = '0;
            end
          end
        end
        S_RUN: begin
          led_n   = decode(cur.mode, idx);
          presc_n = tick ? '0 : presc + DIV_WIDTH'(1);
          if (tick) begin
            idx_n  = advance(cur.mode, idx);
            step_n = 1'b1;
          end
          if (i_pause) state_n = S_PAUSE;
        end
        S_PAUSE: if (!i_pause) state_n = S_RUN;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= S_IDLE;
      cur    <= '{mode: M_OFF, div: DEFAULT_DIV};
      presc  <= '0;
      idx    <= '0;
      blank  <= '0;
      o_led  <= 8'h00;
      o_step <= 1'b0;
    end else begin
      state  <= state_n;
      cur    <= cur_n;
      presc  <= presc_n;
      idx    <= idx_n;
      blank  <= blank_n;
      o_led  <= led_n;
      o_step <= step_n;
    end
  end
endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Scoreboard bench: expected LED values are queued per step; a monitor pops
// one entry for every o_step pulse and compares the LED value one cycle later.
module tb_led_pattern_scheduler;
  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic [2:0]  i_cmd_mode = 3'd0;
  logic [23:0] i_cmd_div = 24'd0;
  logic        i_pause = 1'b0;
  logic        o_cmd_ready, o_step;
  logic [7:0]  o_led;
  logic [2:0]  o_mode;

  always #5 clk = ~clk;

  led_pattern_scheduler dut (
    .i_clk(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid),
    .i_cmd_mode(i_cmd_mode), .i_cmd_div(i_cmd_div), .o_cmd_ready(o_cmd_ready),
    .i_pause(i_pause), .o_led(o_led), .o_step(o_step), .o_mode(o_mode)
  );

  logic [7:0] exp_q[$];
  bit mon_en = 1'b0;
  bit pend   = 1'b0;
  int tests  = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // LED value settles on the cycle after the step pulse.
  always @(negedge clk) begin
    if (pend && mon_en) begin
      if (exp_q.size() == 0) chk("unexpected_step", 1, 0);
      else chk("step_led", {24'd0, o_led}, {24'd0, exp_q.pop_front()});
    end
    pend = o_step;
  end

  task automatic send_cmd(input logic [2:0] m, input logic [23:0] d);
    bit got = 1'b0;
    i_cmd_mode = m; i_cmd_div = d; i_cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_cmd_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("cmd_accept_timeout", 1, 0);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n0);
    n0 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_cmd_ready) return;
      n0++;
      if (o_led !== 8'h00) chk("blank_led", {24'd0, o_led}, 0);
    end
    chk("ready_timeout", 1, 0);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin mon_en = 1'b0; return; end
    end
    chk("drain_timeout", exp_q.size(), 0);
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_led(input logic [7:0] v, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_led == v) return;
    end
    chk("wait_led_timeout", {24'd0, o_led}, {24'd0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bad, steps, k;
    logic [7:0] kit_seq [14];
    kit_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    chk("rst_led", {24'd0, o_led}, 0);
    chk("rst_mode", {29'd0, o_mode}, 0);
    chk("rst_ready", {31'd0, o_cmd_ready}, 1);
    chk("rst_step", {31'd0, o_step}, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_step || o_led != 8'h00 || !o_cmd_ready || o_mode != 3'd0) bad++;
    end
    chk("idle_100", bad, 0);

    // KIT, div 3
    send_cmd(3'd1, 24'd3);
    wait_ready(n);
    chk("kit_blank_cycles", n, 8);
    foreach (kit_seq[i]) exp_q.push_back(kit_seq[i]);
    mon_en = 1'b1;
    @(negedge clk);
    chk("kit_first_led", {24'd0, o_led}, 8'h01);
    chk("kit_mode", {29'd0, o_mode}, 1);
    bad = 0; steps = 0;
    for (int i = 11; i <= 62; i++) begin
      @(negedge clk);
      if (o_step) steps++;
      if (o_step != (((i - 13) % 4 == 0) && i >= 13)) bad++;
    end
    chk("kit_step_cadence", bad, 0);
    chk("kit_step_count", steps, 13);
    drain(40);

    // COUNT, div 0: one step per clock, wraps FF -> 00
    send_cmd(3'd4, 24'd0);
    wait_ready(n);
    chk("count_blank_cycles", n, 2);
    for (int i = 0; i <= 256; i++) exp_q.push_back(8'((i + 1) & 8'hFF));
    mon_en = 1'b1;
    @(negedge clk);
    chk("count_first_led", {24'd0, o_led}, 0);
    chk("count_first_step", {31'd0, o_step}, 1);
    drain(400);

    // CHASE, div 3, pause at 08
    send_cmd(3'd2, 24'd3);
    wait_ready(n);
    chk("chase_blank_cycles", n, 8);
    exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    mon_en = 1'b1;
    wait_led(8'h08, 40);
    i_pause = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_step || o_led != 8'h08) bad++;
    end
    chk("pause_hold", bad, 0);
    i_pause = 1'b0;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (o_step) begin k = i; break; end
    end
    chk("resume_latency", k, 3);
    drain(60);

    // Command on a tick cycle, then a command held through BLANK
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_step) begin k = 1; break; end
    end
    chk("chase_step_seen", k, 1);
    repeat (3) @(negedge clk);
    i_cmd_mode = 3'd3; i_cmd_div = 24'd1; i_cmd_valid = 1'b1;
    @(negedge clk);
    chk("tick_cmd_no_step", {31'd0, o_step}, 0);
    chk("tick_cmd_mode", {29'd0, o_mode}, 3);
    chk("tick_cmd_ready", {31'd0, o_cmd_ready}, 0);
    i_cmd_mode = 3'd4; i_cmd_div = 24'd0;
    n = 1;
    for (int i = 0; i < 20 && !o_cmd_ready; i++) begin
      @(negedge clk);
      if (!o_cmd_ready) n++;
    end
    chk("held_blank_cycles", n, 4);
    chk("held_before_mode", {29'd0, o_mode}, 3);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    @(negedge clk);
    chk("held_accept_mode", {29'd0, o_mode}, 4);
    chk("held_accept_ready", {31'd0, o_cmd_ready}, 0);

    // Reset mid-COUNT overrides a simultaneous command
    wait_led(8'h5A, 400);
    i_reset = 1'b1;
    i_cmd_valid = 1'b1; i_cmd_mode = 3'd4; i_cmd_div = 24'd0;
    @(negedge clk);
    chk("midrst_led", {24'd0, o_led}, 0);
    chk("midrst_mode", {29'd0, o_mode}, 0);
    chk("midrst_ready", {31'd0, o_cmd_ready}, 1);
    chk("midrst_step", {31'd0, o_step}, 0);
    i_reset = 1'b0; i_cmd_valid = 1'b0;

    // Reserved mode maps to OFF / IDLE
    send_cmd(3'd6, 24'd5);
    @(negedge clk);
    chk("mode6_mode", {29'd0, o_mode}, 0);
    chk("mode6_ready", {31'd0, o_cmd_ready}, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_step || o_led != 8'h00 || !o_cmd_ready) bad++;
    end
    chk("mode6_idle", bad, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
